// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch FSM states, PC step, branch opcodes and target helper
package instruction_fetch_unit_pkg;
    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;
    localparam logic [15:0] INSTR_BYTES = 16'd2;
    localparam logic [5:0] OP_JMP = 6'b001110;
    localparam logic [5:0] OP_JZ  = 6'b001101;
    localparam logic [5:0] OP_JNZ = 6'b010011;
    function automatic logic [15:0] branch_target(input logic [15:0] pc, input logic [15:0] off);
        return (pc + off) & 16'hFFFE;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory, decode and redirect signals of the fetch stage
interface instruction_fetch_unit_if;
    logic        ot_imem_req;
    logic [15:0] ot_imem_addr;
    logic        in_imem_valid;
    logic [15:0] in_imem_data;
    logic [15:0] ot_instruction;
    logic        ot_instr_valid;
    logic [15:0] ot_pc;
    logic        in_decode_ready;
    logic        in_branch_taken;
    logic [15:0] in_branch_pc;
    logic [15:0] in_branch_offset;
    modport master (
        output ot_imem_req, ot_imem_addr, ot_instruction, ot_instr_valid, ot_pc,
        input  in_imem_valid, in_imem_data, in_decode_ready, in_branch_taken, in_branch_pc,
               in_branch_offset
    );
    modport slave (
        input  ot_imem_req, ot_imem_addr, ot_instruction, ot_instr_valid, ot_pc,
        output in_imem_valid, in_imem_data, in_decode_ready, in_branch_taken, in_branch_pc,
               in_branch_offset
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches one word at a time and holds it for decode;
// applies taken-branch redirects, dropping any in-flight wrong-path word.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    instruction_fetch_unit_if.master  bus
);
    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_pending;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic [15:0] w_target;
    logic        w_mem_valid;
    assign w_target    = branch_target(bus.in_branch_pc, bus.in_branch_offset);
    assign w_mem_valid = bus.in_imem_valid && r_state != S_HOLD;
    assign bus.ot_imem_req    = !in_rst && r_state != S_HOLD;
    assign bus.ot_imem_addr   = r_pc;
    assign bus.ot_instruction = r_instr;
    assign bus.ot_instr_valid = r_instr_valid;
    assign bus.ot_pc          = r_instr_pc;
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_pending     <= 16'h0000;
            r_instr       <= 16'h0000;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else if (bus.in_branch_taken) begin
            // a response landing with the redirect closes the request; otherwise drain it first
            if (r_state == S_HOLD) begin
                r_instr_valid <= 1'b0;
                r_pc          <= w_target;
                r_state       <= S_FETCH;
            end else if (w_mem_valid) begin
                r_pc    <= w_target;
                r_state <= S_FETCH;
            end else begin
                r_pending <= w_target;
                r_state   <= S_DISCARD;
            end
        end else begin
            case (r_state)
                S_FETCH: if (w_mem_valid) begin
                    r_instr       <= bus.in_imem_data;
                    r_instr_pc    <= r_pc;
                    r_instr_valid <= 1'b1;
                    r_pc          <= r_pc + INSTR_BYTES;
                    r_state       <= S_HOLD;
                end
                S_HOLD: if (bus.in_decode_ready) begin
                    r_instr_valid <= 1'b0;
                    r_state       <= S_FETCH;
                end
                S_DISCARD: if (w_mem_valid) begin
                    r_pc    <= r_pending;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a latency-programmable memory responder
module tb_instruction_fetch_unit;
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();
    instruction_fetch_unit_if bus2();
    instruction_fetch_unit dut (.in_clk(clk), .in_rst(rst), .bus(bus));
    instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (.in_clk(clk), .in_rst(rst), .bus(bus2));

    exp_t        q[$];
    logic [15:0] addr2_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cnt = 0;
    int          cnt2 = 0;
    int          mem_lat = 1;
    bit          mem_en = 1'b1;
    bit          out2 = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    // one clock: drive memory responses, score consumed instructions, then advance
    task automatic step();
        exp_t e;
        if (mem_en) begin
            if (bus.ot_imem_req) begin
                if (cnt >= mem_lat) begin
                    bus.in_imem_valid = 1'b1;
                    bus.in_imem_data  = mem_word(bus.ot_imem_addr);
                    cnt = 0;
                end else begin
                    bus.in_imem_valid = 1'b0;
                    cnt++;
                end
            end else begin
                bus.in_imem_valid = 1'b0;
                cnt = 0;
            end
        end
        if (bus2.ot_imem_req) begin
            if (!out2) addr2_log.push_back(bus2.ot_imem_addr);
            bus2.in_imem_valid = (cnt2 >= 1);
            bus2.in_imem_data  = mem_word(bus2.ot_imem_addr);
            cnt2 = (cnt2 >= 1) ? 0 : cnt2 + 1;
            out2 = !bus2.in_imem_valid;
        end else begin
            bus2.in_imem_valid = 1'b0;
            cnt2 = 0;
            out2 = 1'b0;
        end
        if (!rst && bus.ot_instr_valid && bus.in_decode_ready && !bus.in_branch_taken) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_instr: got pc=%h instr=%h, required no instruction",
                         bus.ot_pc, bus.ot_instruction);
            end else begin
                e = q.pop_front();
                if (bus.ot_pc !== e.pc || bus.ot_instruction !== e.instr) begin
                    miscompares++;
                    $display("FAIL consume: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.ot_pc, bus.ot_instruction, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && q.size() > 0; i++) step();
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors += 4;
        if (bus.ot_imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b, required 0", bus.ot_imem_req); end
        if (bus.ot_instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", bus.ot_instr_valid); end
        if (bus.ot_instruction !== 16'h0000) begin miscompares++; $display("FAIL rst_instr: got %h, required 0000", bus.ot_instruction); end
        if (bus.ot_pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc: got %h, required 0000", bus.ot_pc); end
        rst = 1'b0;
        #1;
        vectors += 2;
        if (bus.ot_imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b, required 1", bus.ot_imem_req); end
        if (bus.ot_imem_addr !== 16'h0000) begin miscompares++; $display("FAIL first_addr: got %h, required 0000", bus.ot_imem_addr); end
    endtask

    task automatic test_basic_fetch();
        bus.in_decode_ready = 1'b1;
        q.push_back('{pc: 16'h0000, instr: 16'h1234});
        step();
        vectors++;
        if (bus.ot_instr_valid !== 1'b0) begin miscompares++; $display("FAIL early_valid: got %b, required 0", bus.ot_instr_valid); end
        step();
        vectors++;
        if (bus.ot_instr_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid: got %b, required 1", bus.ot_instr_valid); end
        step();
        vectors += 2;
        if (bus.ot_imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_req: got %b, required 1", bus.ot_imem_req); end
        if (bus.ot_imem_addr !== 16'h0002) begin miscompares++; $display("FAIL seq_addr: got %h, required 0002", bus.ot_imem_addr); end
    endtask

    task automatic test_stall();
        bus.in_decode_ready = 1'b0;
        q.push_back('{pc: 16'h0002, instr: mem_word(16'h0002)});
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            vectors += 4;
            if (bus.ot_instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b, required 1", i, bus.ot_instr_valid); end
            if (bus.ot_pc !== 16'h0002) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h, required 0002", i, bus.ot_pc); end
            if (bus.ot_instruction !== mem_word(16'h0002)) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h, required %h", i, bus.ot_instruction, mem_word(16'h0002)); end
            if (bus.ot_imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b, required 0", i, bus.ot_imem_req); end
            step();
        end
        bus.in_decode_ready = 1'b1;
        step();
        vectors += 2;
        if (bus.ot_imem_req !== 1'b1) begin miscompares++; $display("FAIL resume_req: got %b, required 1", bus.ot_imem_req); end
        if (bus.ot_imem_addr !== 16'h0004) begin miscompares++; $display("FAIL resume_addr: got %h, required 0004", bus.ot_imem_addr); end
    endtask

    task automatic test_hold_branch();
        bus.in_decode_ready = 1'b0;
        step();
        step();
        vectors++;
        if (bus.ot_instr_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid: got %b, required 1", bus.ot_instr_valid); end
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_pc     = 16'h0010;
        bus.in_branch_offset = 16'hFFF8;
        step();
        bus.in_branch_taken = 1'b0;
        vectors += 3;
        if (bus.ot_instr_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_valid: got %b, required 0", bus.ot_instr_valid); end
        if (bus.ot_imem_req !== 1'b1) begin miscompares++; $display("FAIL redirect_req: got %b, required 1", bus.ot_imem_req); end
        if (bus.ot_imem_addr !== 16'h0008) begin miscompares++; $display("FAIL redirect_addr: got %h, required 0008", bus.ot_imem_addr); end
    endtask

    task automatic test_discard();
        bit saw_valid = 1'b0;
        step();
        step();
        bus.in_branch_taken  = 1'b1;
        bus.in_branch_pc     = 16'h0000;
        bus.in_branch_offset = 16'h0004;
        step();
        vectors++;
        if (bus.ot_imem_addr !== 16'h0004) begin miscompares++; $display("FAIL refetch_addr: got %h, required 0004", bus.ot_imem_addr); end
        bus.in_branch_pc     = 16'h0030;
        bus.in_branch_offset = 16'h0010;
        bus.in_decode_ready  = 1'b1;
        mem_lat = 3;
        step();
        bus.in_branch_taken = 1'b0;
        vectors++;
        if (bus.ot_imem_addr !== 16'h0004 || bus.ot_imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL discard_hold_addr: got req=%b addr=%h, required req=1 addr=0004", bus.ot_imem_req, bus.ot_imem_addr);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.ot_instr_valid) saw_valid = 1'b1;
            if (bus.ot_imem_req && bus.ot_imem_addr == 16'h0040) break;
            step();
        end
        vectors += 2;
        if (saw_valid) begin miscompares++; $display("FAIL discard_pulse: got valid pulse, required none"); end
        if (bus.ot_imem_addr !== 16'h0040) begin miscompares++; $display("FAIL discard_target: got %h, required 0040", bus.ot_imem_addr); end
        mem_lat = 1;
        q.push_back('{pc: 16'h0040, instr: mem_word(16'h0040)});
        drain(10);
    endtask

    task automatic test_wrap();
        vectors += 2;
        if (addr2_log.size() < 2) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d requests, required >= 2", addr2_log.size());
        end else if (addr2_log[0] !== 16'hFFFE || addr2_log[1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h,%h, required fffe,0000", addr2_log[0], addr2_log[1]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        mem_en = 1'b0;
        bus.in_imem_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.in_imem_valid = 1'b1;
        bus.in_imem_data  = 16'hBEEF;
        #1;
        vectors++;
        if (bus.ot_imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_gate_req: got %b, required 0", bus.ot_imem_req); end
        step();
        bus.in_imem_valid = 1'b0;
        vectors += 3;
        if (bus.ot_instr_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b, required 0", bus.ot_instr_valid); end
        if (bus.ot_imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req: got %b, required 0", bus.ot_imem_req); end
        if (bus.ot_pc !== 16'h0000) begin miscompares++; $display("FAIL midrst_pc: got %h, required 0000", bus.ot_pc); end
        rst = 1'b0;
        #1;
        vectors += 2;
        if (bus.ot_imem_req !== 1'b1) begin miscompares++; $display("FAIL postrst_req: got %b, required 1", bus.ot_imem_req); end
        if (bus.ot_imem_addr !== 16'h0000) begin miscompares++; $display("FAIL postrst_addr: got %h, required 0000", bus.ot_imem_addr); end
        mem_en = 1'b1;
        cnt = 0;
        q.push_back('{pc: 16'h0000, instr: 16'h1234});
        drain(10);
    endtask

    initial begin
        bus.in_imem_valid     = 1'b0;
        bus.in_imem_data      = 16'h0000;
        bus.in_decode_ready   = 1'b0;
        bus.in_branch_taken   = 1'b0;
        bus.in_branch_pc      = 16'h0000;
        bus.in_branch_offset  = 16'h0000;
        bus2.in_imem_valid    = 1'b0;
        bus2.in_imem_data     = 16'h0000;
        bus2.in_decode_ready  = 1'b1;
        bus2.in_branch_taken  = 1'b0;
        bus2.in_branch_pc     = 16'h0000;
        bus2.in_branch_offset = 16'h0000;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_wrap();
        test_hold_branch();
        test_discard();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
